trace_monitor: RTL
==================

// Module: trace_monitor
// PURPOSE
//  Synthesizable retire-event tracer for the CPU: captures NCH event channels (reg, csr, store) into a DEPTH-entry buffer with timestamps.
//  Detects the host (tohost) store and a cycle-budget timeout; drains records over a valid/ready port to a bench or debug UART.
//  Sits beside cpu_comp inside soc and is fed from execute-stage commit signals.
// PARAMETERS
//  XLEN     32        data/address width
//  DEPTH    16        trace buffer entries, power of two, >=2
//  NCH      3         event channels; ch0=reg, ch1=csr, ch2=mem (NCH-1 is always the store channel)
//  MAXTIME  10000000  cycle budget before timeout
// PORTS
//  clock       in   1            rising-edge clock
//  reset       in   1            async active-low reset
//  ev_valid    in   NCH          per-channel event strobe
//  ev_pc       in   NCH*XLEN     event PC, channel i at [i*XLEN +: XLEN]
//  ev_addr     in   NCH*XLEN     waddr / caddr / store address
//  ev_data     in   NCH*XLEN     wdata / cwdata / sdata
//  ev_strb     in   NCH*4        byte strobes (ignored for ch < NCH-1)
//  host_addr   in   XLEN         tohost address, word-compared
//  out_valid   out  1            record available
//  out_ready   in   1            sink accepts record
//  out_ch      out  $clog2(NCH)  record channel
//  out_time    out  32           cycle stamp
//  out_pc      out  XLEN
//  out_addr    out  XLEN
//  out_data    out  XLEN
//  out_strb    out  4
//  drop_count  out  16           dropped events, saturating
//  done        out  1            sticky: host store seen
//  done_code   out  XLEN         data of host store
//  timeout     out  1            sticky: budget expired
// BEHAVIOUR
//  Reset: buffer empty, out_valid=0, all out_* =0, drop_count=0, done=0, done_code=0, timeout=0, cycle=0, state=RUN.
//  cycle: 32-bit counter, +1 every clock in RUN, wraps at 2^32; holds in DONE/TIMEOUT.
//  FSM: RUN -> DONE on host store; RUN -> TIMEOUT when cycle==MAXTIME-1 and no host store that cycle; DONE/TIMEOUT terminal until reset.
//   Host store and last budget cycle together -> DONE wins.
//  Store filter: ch NCH-1 event with |ev_strb==0 is ignored (not captured, not counted).
//  Host store: valid ch NCH-1, |strb!=0, addr[XLEN-1:2]==host_addr[XLEN-1:2]; done, done_code set next edge.
//  Capture only in RUN: lowest-index valid channel wins the one write slot/cycle; stamped with cycle.
//   Other valid channels that cycle: dropped, drop_count += their count.
//   Buffer full and no pop that cycle: winner also dropped and counted.
//   Full with simultaneous pop: write accepted (read-before-write).
//  Host store is captured like any store if it wins arbitration and space exists.
//  drop_count saturates at 16'hFFFF, never wraps.
//  Drain: out_* is head entry, registered; pop when out_valid&&out_ready; out_* stable while out_valid&&!out_ready.
//   Write-to-out_valid latency: 1 cycle (entry written at edge N visible after edge N).
//   Draining continues in DONE/TIMEOUT until empty.
//  Pointers: $clog2(DEPTH)+1 bits, wrap modulo DEPTH; full = MSBs differ, low bits equal.
//  Reset mid-operation: async clear of all state, buffer contents discarded, out_valid falls immediately.
// TESTING
//  ch0 valid pc=0x100 data=0xA5 at cycle 5, out_ready=1 -> one record ch=0 time=5 pc=0x100 data=0xA5; drop_count=0.
//  ch0,ch1,ch2(strb=4'hF) valid same cycle -> ch0 recorded; drop_count=2.
//  out_ready=0, DEPTH+3 ch1 events on consecutive cycles -> DEPTH records kept in order; drop_count=3; out_* stable.
//  Store to host_addr=0x80001000, strb=4'h1, data=1 -> done=1, done_code=1; later events not captured; buffer drains fully.
//  MAXTIME=50, no host store -> timeout=1 after 50 cycles; cycle holds at 50; done stays 0.
//  Reset low while 5 entries queued -> out_valid=0 asynchronously, drop_count=0; first post-reset event has time=0 if at first RUN cycle.

Source files
------------

// File: rtl/trace_monitor.sv
// -----------------------------------------------------------------------------
// trace_monitor
//   Retire-event tracer. Captures up to NCH commit-event channels (reg, csr,
//   store) into a DEPTH-entry buffer, stamping each record with a free-running
//   cycle count. It also detects the tohost store (done) and the cycle-budget
//   expiry (timeout). Records drain over a valid/ready port.
//
// Ports
//   clock / reset        rising-edge clock, asynchronous active-low reset
//   ev_valid[NCH]        per-channel event strobe
//   ev_pc/addr/data      channel i occupies [i*XLEN +: XLEN]
//   ev_strb[NCH*4]       byte strobes, meaningful only on the store channel
//   host_addr            tohost address, compared on word granularity
//   out_*                head record; out_valid/out_ready handshake
//   drop_count           saturating count of events that were not captured
//   done / done_code     sticky tohost-store flag and its store data
//   timeout              sticky cycle-budget-expired flag
// -----------------------------------------------------------------------------
module trace_monitor #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 16,
  parameter int NCH     = 3,
  parameter int MAXTIME = 10000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NCH-1:0]            ev_valid,
  input  logic [NCH*XLEN-1:0]       ev_pc,
  input  logic [NCH*XLEN-1:0]       ev_addr,
  input  logic [NCH*XLEN-1:0]       ev_data,
  input  logic [NCH*4-1:0]          ev_strb,
  input  logic [XLEN-1:0]           host_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NCH)-1:0]    out_ch,
  output logic [31:0]               out_time,
  output logic [XLEN-1:0]           out_pc,
  output logic [XLEN-1:0]           out_addr,
  output logic [XLEN-1:0]           out_data,
  output logic [3:0]                out_strb,
  output logic [15:0]               drop_count,
  output logic                      done,
  output logic [XLEN-1:0]           done_code,
  output logic                      timeout
);

  localparam int CHW = $clog2(NCH);
  localparam int CW  = $clog2(NCH + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam int ST  = NCH - 1;   // store channel index

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  // Number of set bits in the effective-valid vector
  function automatic logic [CW-1:0] count_ones(input logic [NCH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < NCH; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      cycle_q, cycle_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]      drop_q, drop_d;
  logic [XLEN-1:0]  done_code_q, done_code_d;

  logic             out_valid_q, out_valid_d;
  logic [CHW-1:0]   out_ch_q, out_ch_d;
  logic [31:0]      out_time_q, out_time_d;
  logic [XLEN-1:0]  out_pc_q, out_pc_d, out_addr_q, out_addr_d, out_data_q, out_data_d;
  logic [3:0]       out_strb_q, out_strb_d;

  // Buffer storage, one array per record field
  logic [CHW-1:0]   mem_ch   [DEPTH];
  logic [31:0]      mem_time [DEPTH];
  logic [XLEN-1:0]  mem_pc   [DEPTH];
  logic [XLEN-1:0]  mem_addr [DEPTH];
  logic [XLEN-1:0]  mem_data [DEPTH];
  logic [3:0]       mem_strb [DEPTH];

  logic [NCH-1:0]   ev_eff;
  logic             host_hit, in_run, full, pop, wr_en, win_any;
  logic [CHW-1:0]   win_idx;
  logic [CW-1:0]    ev_cnt, drop_inc;
  logic [16:0]      drop_sum;
  logic [XLEN-1:0]  new_pc, new_addr, new_data;
  logic [3:0]       new_strb;
  logic [AW-1:0]    head_idx;
  logic             unused_bits;

  assign unused_bits = ^{host_addr[1:0], ev_strb[ST*4-1:0]};

  // Qualify events: a store with no byte enables is not an event at all
  always_comb begin
    ev_eff     = ev_valid;
    ev_eff[ST] = ev_valid[ST] & (|ev_strb[ST*4 +: 4]);
  end

  assign host_hit = ev_eff[ST] &&
                    (ev_addr[ST*XLEN + 2 +: XLEN-2] == host_addr[XLEN-1:2]);
  assign in_run   = (state_q == ST_RUN);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop      = out_valid_q && out_ready;
  assign ev_cnt   = count_ones(ev_eff);

  // Fixed-priority arbitration: lowest-index valid channel wins the write slot
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ev_eff[i]) begin
        win_idx = CHW'(i);
        win_any = 1'b1;
      end else begin
        win_idx = win_idx;
      end
    end
  end

  // A full buffer still accepts a write when the head leaves in the same cycle
  assign wr_en    = in_run && win_any && (!full || pop);
  assign drop_inc = in_run ? (ev_cnt - CW'(wr_en)) : '0;
  assign drop_sum = {1'b0, drop_q} + 17'(drop_inc);
  assign drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  assign new_pc   = ev_pc  [win_idx*XLEN +: XLEN];
  assign new_addr = ev_addr[win_idx*XLEN +: XLEN];
  assign new_data = ev_data[win_idx*XLEN +: XLEN];
  assign new_strb = (win_idx == CHW'(ST)) ? ev_strb[ST*4 +: 4] : 4'h0;

  assign wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  assign head_idx = rd_ptr_d[AW-1:0];
  assign cycle_d  = in_run ? (cycle_q + 32'd1) : cycle_q;

  // Control FSM: RUN until tohost store (priority) or budget expiry
  always_comb begin
    state_d     = state_q;
    done_code_d = done_code_q;
    case (state_q)
      ST_RUN: begin
        if (host_hit) begin
          state_d     = ST_DONE;
          done_code_d = ev_data[ST*XLEN +: XLEN];
        end else if (cycle_q == 32'(MAXTIME - 1)) begin
          state_d = ST_TIMEOUT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE:    state_d = ST_DONE;
      ST_TIMEOUT: state_d = ST_TIMEOUT;
      default:    state_d = ST_RUN;
    endcase
  end

  // Output register tracks the head as it will be after this edge, so a write
  // into an otherwise empty buffer is visible right after the writing edge.
  always_comb begin
    out_valid_d = (rd_ptr_d != wr_ptr_d);
    out_ch_d    = '0;
    out_time_d  = 32'd0;
    out_pc_d    = '0;
    out_addr_d  = '0;
    out_data_d  = '0;
    out_strb_d  = 4'h0;
    if (!out_valid_d) begin
      out_ch_d = '0;
    end else if (wr_en && (rd_ptr_d == wr_ptr_q)) begin
      out_ch_d   = win_idx;
      out_time_d = cycle_q;
      out_pc_d   = new_pc;
      out_addr_d = new_addr;
      out_data_d = new_data;
      out_strb_d = new_strb;
    end else begin
      out_ch_d   = mem_ch[head_idx];
      out_time_d = mem_time[head_idx];
      out_pc_d   = mem_pc[head_idx];
      out_addr_d = mem_addr[head_idx];
      out_data_d = mem_data[head_idx];
      out_strb_d = mem_strb[head_idx];
    end
  end

  // Buffer write port; contents need no reset since pointers define validity
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_ch  [wr_ptr_q[AW-1:0]] <= win_idx;
      mem_time[wr_ptr_q[AW-1:0]] <= cycle_q;
      mem_pc  [wr_ptr_q[AW-1:0]] <= new_pc;
      mem_addr[wr_ptr_q[AW-1:0]] <= new_addr;
      mem_data[wr_ptr_q[AW-1:0]] <= new_data;
      mem_strb[wr_ptr_q[AW-1:0]] <= new_strb;
    end
  end

  // State, pointers, counters and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      cycle_q     <= 32'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      drop_q      <= 16'd0;
      done_code_q <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_time_q  <= 32'd0;
      out_pc_q    <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_strb_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      drop_q      <= drop_d;
      done_code_q <= done_code_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_time_q  <= out_time_d;
      out_pc_q    <= out_pc_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_strb_q  <= out_strb_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_time   = out_time_q;
  assign out_pc     = out_pc_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;
  assign out_strb   = out_strb_q;
  assign drop_count = drop_q;
  assign done       = (state_q == ST_DONE);
  assign done_code  = done_code_q;
  assign timeout    = (state_q == ST_TIMEOUT);

endmodule
